voice_allocator: RTL

- Sequences note events onto a bank of NUM_VOICES oscillator voices, each of which feeds a TopLevel-style oscillator taking WaveType[1:0].
- On each note event it picks a target voice: retrigger, free voice, or steal of the oldest voice.
- It then updates that voice's gate, note and wave type, and pulses a load strobe so the voice restarts its phase.
- It sits between the note-event source and the oscillator bank.

---
 rtl/synth_voice_pkg.sv | 20 ++
 rtl/voice_scan.sv | 76 +++++++
 rtl/voice_allocator.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/synth_voice_pkg.sv
// Shared types and constants for the voice allocator and the oscillator bank it feeds.
package synth_voice_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } voice_state_e;

   // Wave-type encoding understood by the oscillator WaveType input.
   localparam int WAVE_W = 2;
   localparam logic [WAVE_W-1:0] WAVE_SINE   = 2'b00;
   localparam logic [WAVE_W-1:0] WAVE_SQUARE = 2'b01;
   localparam logic [WAVE_W-1:0] WAVE_SAW    = 2'b10;
   localparam logic [WAVE_W-1:0] WAVE_TRI    = 2'b11;

   localparam int DEF_NOTE_W = 7;
   localparam int DEF_AGE_W  = 8;

endpackage

// File: rtl/voice_scan.sv
// Walks the voice bank one voice per cycle, keeping the match / free / oldest candidates.
module voice_scan
   import synth_voice_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int NOTE_W     = DEF_NOTE_W,
   parameter int AGE_W      = DEF_AGE_W,
   parameter int IDX_W      = 2
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              step,
   input  logic [NOTE_W-1:0] evt_note,
   input  logic              cur_gate,
   input  logic [NOTE_W-1:0] cur_note,
   input  logic [AGE_W-1:0]  cur_age,
   output logic [IDX_W-1:0]  index,
   output logic              last,
   output logic              match_found,
   output logic [IDX_W-1:0]  target,
   output logic              steal
);

   logic [IDX_W-1:0] match_idx;
   logic [IDX_W-1:0] free_idx;
   logic [IDX_W-1:0] old_idx;
   logic [AGE_W-1:0] old_age;
   logic             free_found;
   logic             old_found;

   assign last = (index == IDX_W'(NUM_VOICES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         index       <= '0;
         match_found <= 1'b0;
         free_found  <= 1'b0;
         old_found   <= 1'b0;
      end else if (clear) begin
         index       <= '0;
         match_found <= 1'b0;
         free_found  <= 1'b0;
         old_found   <= 1'b0;
         match_idx   <= '0;
         free_idx    <= '0;
         old_idx     <= '0;
         old_age     <= '0;
      end else if (step) begin
         if (cur_gate && (cur_note == evt_note) && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= index;
         end
         if (!cur_gate && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= index;
         end
         // Strict compare keeps the lowest index on equal ages.
         if (cur_gate && (!old_found || (cur_age > old_age))) begin
            old_found <= 1'b1;
            old_idx   <= index;
            old_age   <= cur_age;
         end
         if (!last) index <= index + 1'b1;
      end
   end

   always_comb begin
      target = old_idx;
      steal  = 1'b0;
      if (match_found)     target = match_idx;
      else if (free_found) target = free_idx;
      else                 steal  = 1'b1;
   end

endmodule

// File: rtl/voice_allocator.sv
// Note-event to voice-bank allocator: retrigger, free voice, or steal the oldest.
// Optional sustain pedal support is enabled by defining VOICE_ALLOC_SUSTAIN_EN.
module voice_allocator
   import synth_voice_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int NOTE_W     = DEF_NOTE_W,
   parameter int AGE_W      = DEF_AGE_W
)(
   input  logic                         Clock,
   input  logic                         Reset,
   input  logic                         EvtValid,
   output logic                         EvtReady,
   input  logic                         EvtNoteOn,
   input  logic [NOTE_W-1:0]            EvtNote,
   input  logic [WAVE_W-1:0]            EvtWaveType,
`ifdef VOICE_ALLOC_SUSTAIN_EN
   input  logic                         Sustain,
`endif
   output logic [NUM_VOICES-1:0]        VoiceGate,
   output logic [NUM_VOICES*NOTE_W-1:0] VoiceNote,
   output logic [NUM_VOICES*WAVE_W-1:0] VoiceWaveType,
   output logic [NUM_VOICES-1:0]        VoiceLoad,
   output logic                         Stolen
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
      return (&a) ? a : a + 1'b1;
   endfunction

   voice_state_e      state;
   logic              accept;
   logic              release_now;
   logic              evt_on;
   logic [NOTE_W-1:0] evt_note;
   logic [WAVE_W-1:0] evt_wave;
   logic [NOTE_W-1:0] note_r [NUM_VOICES];
   logic [WAVE_W-1:0] wave_r [NUM_VOICES];
   logic [AGE_W-1:0]  age_r  [NUM_VOICES];

   logic [IDX_W-1:0]  scan_index;
   logic              scan_last;
   logic              match_found;
   logic [IDX_W-1:0]  target;
   logic              steal;

`ifdef VOICE_ALLOC_SUSTAIN_EN
   logic                  sustain_q;
   logic                  rel_pend;
   logic [NUM_VOICES-1:0] sus;
   assign release_now = (state == IDLE) & rel_pend;
`else
   assign release_now = 1'b0;
`endif

   assign EvtReady = (state == IDLE) & ~Reset & ~release_now;
   assign accept   = EvtValid & EvtReady;

   genvar g;
   for (g = 0; g < NUM_VOICES; g++) begin : g_flat
      assign VoiceNote[g*NOTE_W +: NOTE_W]     = note_r[g];
      assign VoiceWaveType[g*WAVE_W +: WAVE_W] = wave_r[g];
   end

   voice_scan #(
      .NUM_VOICES (NUM_VOICES),
      .NOTE_W     (NOTE_W),
      .AGE_W      (AGE_W),
      .IDX_W      (IDX_W)
   ) u_scan (
      .clk         (Clock),
      .rst         (Reset),
      .clear       (accept),
      .step        (state == SCAN),
      .evt_note    (evt_note),
      .cur_gate    (VoiceGate[scan_index]),
      .cur_note    (note_r[scan_index]),
      .cur_age     (age_r[scan_index]),
      .index       (scan_index),
      .last        (scan_last),
      .match_found (match_found),
      .target      (target),
      .steal       (steal)
   );

   // Event latch holds data only; state reset alone discards an in-flight event.
   always_ff @(posedge Clock) begin
      if (accept) begin
         evt_on   <= EvtNoteOn;
         evt_note <= EvtNote;
         evt_wave <= EvtWaveType;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= IDLE;
         VoiceGate <= '0;
         VoiceLoad <= '0;
         Stolen    <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            note_r[i] <= '0;
            wave_r[i] <= '0;
            age_r[i]  <= '0;
         end
`ifdef VOICE_ALLOC_SUSTAIN_EN
         sustain_q <= 1'b0;
         rel_pend  <= 1'b0;
         sus       <= '0;
`endif
      end else begin
         VoiceLoad <= '0;
         Stolen    <= 1'b0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
         sustain_q <= Sustain;
         if (sustain_q && !Sustain) rel_pend <= 1'b1;
         else if (release_now)      rel_pend <= 1'b0;
`endif
         case (state)
            IDLE: begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
               if (release_now) begin
                  VoiceGate <= VoiceGate & ~sus;
                  sus       <= '0;
               end
`endif
               if (accept) state <= SCAN;
            end
            SCAN: begin
               if (scan_last) state <= COMMIT;
            end
            COMMIT: begin
               state <= IDLE;
               if (evt_on) begin
                  Stolen <= steal;
                  for (int i = 0; i < NUM_VOICES; i++) begin
                     if (i == int'(target)) begin
                        VoiceGate[i] <= 1'b1;
                        note_r[i]    <= evt_note;
                        wave_r[i]    <= evt_wave;
                        age_r[i]     <= '0;
                        VoiceLoad[i] <= 1'b1;
`ifdef VOICE_ALLOC_SUSTAIN_EN
                        sus[i]       <= 1'b0;
`endif
                     end else if (VoiceGate[i]) begin
                        age_r[i] <= sat_inc(age_r[i]);
                     end
                  end
               end else if (match_found) begin
                  for (int i = 0; i < NUM_VOICES; i++) begin
                     if (i == int'(target)) begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
                        if (Sustain) sus[i]       <= 1'b1;
                        else         VoiceGate[i] <= 1'b0;
`else
                        VoiceGate[i] <= 1'b0;
`endif
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
